// File: rtl/pulse_period_meter.sv
// Measures rising-edge spacing of pulse_in in clk cycles with a valid/ready result port.
// Optional input synchronizer: define PULSE_PERIOD_METER_SYNC_EN.
module pulse_period_meter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overflow,
    output logic             dropped
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] counter_next;
    logic             capture;
    logic             sig;
    logic             p_q;
    logic             pulse_edge;

`ifdef PULSE_PERIOD_METER_SYNC_EN
    logic sync_1;
    logic sync_2;

    // Reset high so a line held high through reset does not look like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= pulse_in;
            sync_2 <= sync_1;
        end
    end

    assign sig = sync_2;
`else
    assign sig = pulse_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= 1'b1;
        end else begin
            p_q <= sig;
        end
    end

    assign pulse_edge = sig & ~p_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        capture      = 1'b0;
        if (!enable) begin
            state_next   = IDLE;
            counter_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ARM;
                end
                ARM: begin
                    if (pulse_edge) begin
                        counter_next = CNT_ONE;
                        state_next   = MEASURE;
                    end
                end
                MEASURE: begin
                    if (pulse_edge) begin
                        capture      = 1'b1;
                        counter_next = CNT_ONE;
                    end else if (counter != CNT_MAX) begin
                        counter_next = counter + CNT_ONE;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    counter_next = '0;
                end
            endcase
        end
    end

    // A capture overwrites the held result only if the slot is empty or draining this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            period       <= '0;
            overflow     <= 1'b0;
            period_valid <= 1'b0;
            dropped      <= 1'b0;
        end else begin
            dropped <= 1'b0;
            if (capture) begin
                if (!period_valid || period_ready) begin
                    period       <= counter;
                    overflow     <= (counter == CNT_MAX);
                    period_valid <= 1'b1;
                end else begin
                    dropped <= 1'b1;
                end
            end else if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bit width of the period counter and result.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1  measurement enable.
REQ-005 SHALL have port pulse_in  input  1  pulse/tick stream whose rising-edge spacing is measured.
REQ-006 SHALL have port period  output  WIDTH  measured edge-to-edge interval in clk cycles.
REQ-007 SHALL have port period_valid  output  1  period holds an unconsumed result.
REQ-008 SHALL have port period_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port overflow  output  1  held result saturated; qualified by period_valid.
REQ-010 SHALL have port dropped  output  1  one-cycle pulse when a completed measurement is discarded.

Function
REQ-011 SHALL register pulse_in into p_q each cycle; edge = pulse_in & ~p_q.
REQ-012 SHALL implement FSM states IDLE, ARM, MEASURE.
REQ-013 SHALL go from any state to IDLE when enable=0; counter cleared; edges ignored.
REQ-014 SHALL go IDLE -> ARM when enable=1; the first edge in ARM loads counter=1 and enters MEASURE, with no result produced.
REQ-015 SHALL, in MEASURE on a cycle without edge, increment counter, saturating at 2^WIDTH-1.
REQ-016 SHALL, in MEASURE on an edge cycle, capture result=counter and flag=(counter==2^WIDTH-1), then reload counter=1 and stay in MEASURE.
REQ-017 SHALL yield, for edges detected at cycles t0 and t0+N, result=min(N, 2^WIDTH-1).
REQ-018 SHALL present a captured result on period/overflow with period_valid=1 in the cycle after the edge.
REQ-019 SHALL complete a transfer when period_valid and period_ready are both 1; period_valid then clears next cycle unless a new capture occurs.
REQ-020 SHALL, when a capture coincides with a transfer, load the new result and keep period_valid=1.
REQ-021 SHALL, when a capture occurs while period_valid=1 and period_ready=0, keep the held result unchanged and pulse dropped for exactly one cycle.
REQ-022 SHALL keep period and overflow stable while period_valid=1 and not transferred.
REQ-023 SHALL retain any pending result across enable deassertion until transferred.

Reset
REQ-024 SHALL, while rst=1, set state=IDLE, counter=0, p_q=1, period=0, period_valid=0, overflow=0, dropped=0.
REQ-025 SHALL discard any in-progress measurement and pending result on reset; rst has priority over all other inputs.
REQ-026 SHALL not detect an edge on the first post-reset cycle if pulse_in is held high through reset.

Configuration
REQ-027 SHALL, with PULSE_PERIOD_METER_SYNC_EN defined, pass pulse_in through a two-flop synchronizer (reset value 1) before edge detection, adding 2 cycles to result latency with period values unchanged.
REQ-028 SHALL, without PULSE_PERIOD_METER_SYNC_EN, sample pulse_in directly, assuming a clk-synchronous source.

Verification
REQ-029 SHALL cover: WIDTH=8, enable=1, period_ready=1, one-cycle pulses every 10 cycles -> no result after first pulse; each later pulse gives period=10, overflow=0, period_valid one cycle after the edge.
REQ-030 SHALL cover: pulses 300 cycles apart -> period=255, overflow=1.
REQ-031 SHALL cover: period_ready=0, pulses every 20 cycles -> first result 20 held; dropped pulses once per later edge; raising period_ready transfers 20.
REQ-032 SHALL cover: period_ready asserted in the same cycle as the next capture (periods 12 then 7) -> 12 transferred, period_valid stays 1 with period=7.
REQ-033 SHALL cover: rst mid-MEASURE (counter=5), then pulses every 8 cycles -> all outputs 0 during rst; first post-reset pulse only arms; next result 8.
REQ-034 SHALL cover: PULSE_PERIOD_METER_SYNC_EN defined, pulses every 10 cycles -> period=10, period_valid 3 cycles after the raw pulse_in rising edge.
